// File: rtl/fft_data_input.sv
// Frame buffer feeding the FFT engine: CPU writes {RE, IM} words into RAM, then a
// start pulse streams POINT_SIZE beats out over AXI-Stream. Option: FFT_DATA_INPUT_WRITE_LOCK_EN.
module fft_data_input #(
  parameter int NFFT               = 3,
  parameter int POINT_SIZE         = 2**NFFT,
  parameter int N_ELEMENTS         = POINT_SIZE*2,
  parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wEn,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] wAddr,
  input  logic [31:0]                   wData,
  input  logic                          start,
  output logic                          tvalid,
  input  logic                          tready,
  output logic                          tlast,
  output logic [63:0]                   tdata,
  output logic                          busy,
  output logic                          sent
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SENDING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [NFFT-1:0] LAST_POINT = NFFT'(POINT_SIZE-1);

  state_t                        r_state;
  state_t                        w_stateNext;
  logic [NFFT-1:0]               r_pointI;
  logic [NFFT-1:0]               w_loadPoint;
  logic [63:0]                   r_tdata;
  logic [31:0]                   r_ram [N_ELEMENTS];
  logic                          w_tvalid;
  logic                          w_busy;
  logic                          w_handshake;
  logic                          w_lastPoint;
  logic                          w_launch;
  logic                          w_advance;
  logic                          w_ramWe;
  logic [ELEMENTS_ADDR_SIZE-1:0] w_rdAddrRe;
  logic [ELEMENTS_ADDR_SIZE-1:0] w_rdAddrIm;

  assign w_tvalid    = (r_state == SENDING);
  assign w_busy      = (r_state == SENDING) || (r_state == DONE);
  assign w_lastPoint = (r_pointI == LAST_POINT);
  assign w_handshake = w_tvalid && tready;

  always_comb begin
    w_stateNext = r_state;
    w_launch    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = SENDING;
          w_launch    = 1'b1;
        end
      end
      SENDING: begin
        if (w_handshake) begin
          if (w_lastPoint) w_stateNext = DONE;
          else             w_advance   = 1'b1;
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Next point to present: point 0 on launch, otherwise the one after the current beat
  assign w_loadPoint = w_launch ? '0 : (r_pointI + 1'b1);
  assign w_rdAddrRe  = ELEMENTS_ADDR_SIZE'({w_loadPoint, 1'b0});
  assign w_rdAddrIm  = ELEMENTS_ADDR_SIZE'({w_loadPoint, 1'b1});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_pointI <= '0;
      r_tdata  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_launch)       r_pointI <= '0;
      else if (w_advance) r_pointI <= r_pointI + 1'b1;
      if (w_launch || w_advance)
        r_tdata <= {r_ram[w_rdAddrIm], r_ram[w_rdAddrRe]};
    end
  end

`ifdef FFT_DATA_INPUT_WRITE_LOCK_EN
  logic [7:0] lockDrops;

  assign w_ramWe = wEn && !w_busy;

  // Counts writes rejected because a frame was in flight; sticks at 255
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      lockDrops <= '0;
    else if (wEn && w_busy && (lockDrops != 8'hFF))
      lockDrops <= lockDrops + 8'd1;
  end
`else
  assign w_ramWe = wEn;
`endif

  // Frame storage deliberately has no reset so contents survive resetn
  always_ff @(posedge clk) begin
    if (w_ramWe) r_ram[wAddr] <= wData;
  end

  assign tvalid = w_tvalid;
  assign tlast  = w_tvalid && w_lastPoint;
  assign tdata  = r_tdata;
  assign busy   = w_busy;
  assign sent   = (r_state == DONE);

endmodule

// File: tb/tb_fft_data_input.sv
// Bench for fft_data_input: vector table plus scoreboard of expected beats, with
// backpressure, start-while-busy, mid-frame reset/write and an NFFT=1 instance.
module tb_fft_data_input;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        wEn = 1'b0;
  logic [3:0]  wAddr = '0;
  logic [31:0] wData = '0;
  logic        start = 1'b0;
  logic        tready = 1'b0;
  logic        tvalid, tlast, busy, sent;
  logic [63:0] tdata;

  logic        t_wEn = 1'b0;
  logic [1:0]  t_wAddr = '0;
  logic [31:0] t_wData = '0;
  logic        t_start = 1'b0;
  logic        t_tready = 1'b0;
  logic        t_tvalid, t_tlast, t_busy, t_sent;
  logic [63:0] t_tdata;

  fft_data_input #(.NFFT(3)) dut (
    .clk(clk), .resetn(resetn), .wEn(wEn), .wAddr(wAddr), .wData(wData),
    .start(start), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .tdata(tdata), .busy(busy), .sent(sent)
  );

  fft_data_input #(.NFFT(1)) dut2 (
    .clk(clk), .resetn(resetn), .wEn(t_wEn), .wAddr(t_wAddr), .wData(t_wData),
    .start(t_start), .tvalid(t_tvalid), .tready(t_tready), .tlast(t_tlast),
    .tdata(t_tdata), .busy(t_busy), .sent(t_sent)
  );

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [63:0] exp_data;
    logic        exp_last;
  } vec_t;

  localparam logic [3:0]  WR_ADDR = 4'd12;
  localparam logic [31:0] WR_DATA = 32'h0000_DEAD;

  vec_t        tbl [8];
  logic [31:0] mem [16];
  logic [64:0] q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wEn = 1'b1; wAddr = a; wData = d;
    @(negedge clk);
    wEn = 1'b0;
  endtask

  function automatic logic [64:0] exp_beat(input int k);
    logic [3:0] a;
    a = 4'(2*k);
    return {(k == 7), mem[a + 4'd1], mem[a]};
  endfunction

  task automatic push_frame();
    for (int k = 0; k < 8; k++) q.push_back(exp_beat(k));
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'b1;
  endfunction

  // Called at the negedge after start was accepted; consumes one frame from q
  task automatic drive_frame(input int mode, input int sb, input int wb, input bit start_done);
    int          hs = 0;
    int          cyc = 0;
    bit          ps = 1'b0;
    bit          sfired = 1'b0;
    bit          wfired = 1'b0;
    logic [63:0] pd = '0;
    logic        pl = 1'b0;
    logic [64:0] e;
    while (hs < 8 && cyc < 200) begin
      tready = rdy(mode, cyc);
      start  = 1'b0;
      wEn    = 1'b0;
      if (hs == sb && !sfired) begin start = 1'b1; sfired = 1'b1; end
      if (hs == wb && !wfired) begin
        wEn = 1'b1; wAddr = WR_ADDR; wData = WR_DATA; wfired = 1'b1;
      end
      if (!tvalid) begin
        chk("tvalid_in_frame", tvalid, 1'b1);
        break;
      end
      if (ps) begin
        chk("stall_tdata", tdata, pd);
        chk("stall_tlast", tlast, pl);
      end
      if (tready) begin
        e = (q.size() > 0) ? q.pop_front() : 65'h0;
        chk("beat_tdata", tdata, e[63:0]);
        chk("beat_tlast", tlast, e[64]);
        hs++;
      end
      ps = !tready; pd = tdata; pl = tlast;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; wEn = 1'b0; tready = 1'b0;
    chk("handshakes", hs, 8);
    chk("queue_empty", q.size(), 0);
    chk("done_sent", sent, 1'b1);
    chk("done_tvalid", tvalid, 1'b0);
    chk("done_busy", busy, 1'b1);
    if (start_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_sent", sent, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_tvalid", tvalid, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].re       = 32'(k);
      tbl[k].im       = 32'h100 + 32'(k);
      tbl[k].exp_data = {32'h100 + 32'(k), 32'(k)};
      tbl[k].exp_last = (k == 7);
    end

    @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", sent, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic frame from the vector table
    for (int k = 0; k < 8; k++) begin
      wr(4'(2*k), tbl[k].re);
      wr(4'(2*k+1), tbl[k].im);
      mem[2*k]   = tbl[k].re;
      mem[2*k+1] = tbl[k].im;
      q.push_back({tbl[k].exp_last, tbl[k].exp_data});
    end
    start_frame();
    drive_frame(0, -1, -1, 1'b0);

    // Backpressure
    push_frame();
    start_frame();
    drive_frame(1, -1, -1, 1'b0);

    // Start while busy (beat 3 and in DONE), then a fresh frame
    push_frame();
    start_frame();
    drive_frame(0, 3, -1, 1'b1);
    @(negedge clk);
    chk("no_restart_tvalid", tvalid, 1'b0);
    chk("no_restart_busy", busy, 1'b0);
    push_frame();
    start_frame();
    drive_frame(0, -1, -1, 1'b0);

    // Write to ram[12] while beat 2 is presented
`ifndef FFT_DATA_INPUT_WRITE_LOCK_EN
    mem[WR_ADDR] = WR_DATA;
`endif
    push_frame();
    start_frame();
    drive_frame(0, -1, 2, 1'b0);
`ifdef FFT_DATA_INPUT_WRITE_LOCK_EN
    chk("lock_drops", dut.lockDrops, 64'd1);
`endif

    // Reset after beat 4, then a fresh frame from retained RAM
    start_frame();
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("pre_rst_beat", tdata, {mem[4'(2*k+1)], mem[4'(2*k)]});
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_tvalid", tvalid, 1'b0);
    chk("async_rst_tlast", tlast, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_sent", sent, 1'b0);
    tready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    push_frame();
    start_frame();
    chk("post_rst_beat0", tdata, {32'h100, 32'h0});
    drive_frame(0, -1, -1, 1'b0);

    // NFFT=1 instance
    begin
      int beats = 0;
      int sents = 0;
      for (int k = 0; k < 2; k++) begin
        t_wEn = 1'b1; t_wAddr = 2'(2*k); t_wData = 32'hA0 + 32'(k);
        @(negedge clk);
        t_wAddr = 2'(2*k+1); t_wData = 32'hB0 + 32'(k);
        @(negedge clk);
      end
      t_wEn = 1'b0;
      t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      t_tready = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (t_sent) sents++;
        if (t_tvalid && t_tready) begin
          chk("tiny_tdata", t_tdata, {32'hB0 + 32'(beats), 32'hA0 + 32'(beats)});
          chk("tiny_tlast", t_tlast, (beats == 1));
          beats++;
        end
        @(negedge clk);
      end
      chk("tiny_beats", beats, 2);
      chk("tiny_sent", sents, 1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
